// File: rtl/reg_bus_arbiter.sv
// Two-requester round-robin arbiter for the single-cycle register request bus.
// One access outstanding; acks and read data are routed back to the owner, and hung accesses time out.
module reg_bus_arbiter #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  s0_wr_req,
    input  logic                  s0_rd_req,
    input  logic [ADDR_WIDTH-1:0] s0_addr,
    input  logic [DATA_WIDTH-1:0] s0_wdata,
    output logic                  s0_wr_ack,
    output logic                  s0_rd_ack,
    output logic [DATA_WIDTH-1:0] s0_rdata,
    output logic                  s0_err,
    input  logic                  s1_wr_req,
    input  logic                  s1_rd_req,
    input  logic [ADDR_WIDTH-1:0] s1_addr,
    input  logic [DATA_WIDTH-1:0] s1_wdata,
    output logic                  s1_wr_ack,
    output logic                  s1_rd_ack,
    output logic [DATA_WIDTH-1:0] s1_rdata,
    output logic                  s1_err,
    output logic                  m_wr_req,
    output logic                  m_rd_req,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic [DATA_WIDTH-1:0] m_wdata,
    input  logic                  m_wr_ack,
    input  logic                  m_rd_ack,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    output logic                  overrun,
    output logic                  timeout
);

    localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    typedef struct packed {
        logic                  valid;
        logic                  wr;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } slot_t;

    logic [1:0]            req_wr;
    logic [1:0]            req_rd;
    logic [ADDR_WIDTH-1:0] req_addr [2];
    logic [DATA_WIDTH-1:0] req_wdata [2];

    state_t                state_q, state_d;
    slot_t                 slot_q [2];
    slot_t                 slot_d [2];
    logic                  last_q, last_d;
    logic                  owner_q, owner_d;
    logic                  kind_q, kind_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  m_wr_req_q, m_wr_req_d;
    logic                  m_rd_req_q, m_rd_req_d;
    logic [ADDR_WIDTH-1:0] m_addr_q, m_addr_d;
    logic [DATA_WIDTH-1:0] m_wdata_q, m_wdata_d;
    logic [1:0]            wr_ack_q, wr_ack_d;
    logic [1:0]            rd_ack_q, rd_ack_d;
    logic [1:0]            err_q, err_d;
    logic [DATA_WIDTH-1:0] rdata_q [2];
    logic [DATA_WIDTH-1:0] rdata_d [2];
    logic                  overrun_q, overrun_d;
    logic                  timeout_q, timeout_d;
    logic                  grant;
    logic                  owner_busy;

    assign req_wr       = {s1_wr_req, s0_wr_req};
    assign req_rd       = {s1_rd_req, s0_rd_req};
    assign req_addr[0]  = s0_addr;
    assign req_addr[1]  = s1_addr;
    assign req_wdata[0] = s0_wdata;
    assign req_wdata[1] = s1_wdata;

    assign s0_wr_ack = wr_ack_q[0];
    assign s1_wr_ack = wr_ack_q[1];
    assign s0_rd_ack = rd_ack_q[0];
    assign s1_rd_ack = rd_ack_q[1];
    assign s0_err    = err_q[0];
    assign s1_err    = err_q[1];
    assign s0_rdata  = rdata_q[0];
    assign s1_rdata  = rdata_q[1];
    assign m_wr_req  = m_wr_req_q;
    assign m_rd_req  = m_rd_req_q;
    assign m_addr    = m_addr_q;
    assign m_wdata   = m_wdata_q;
    assign overrun   = overrun_q;
    assign timeout   = timeout_q;

    // Next-state: grant/complete FSM plus per-requester slot intake.
    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        last_d     = last_q;
        owner_d    = owner_q;
        kind_d     = kind_q;
        cnt_d      = cnt_q;
        m_wr_req_d = 1'b0;
        m_rd_req_d = 1'b0;
        m_addr_d   = m_addr_q;
        m_wdata_d  = m_wdata_q;
        wr_ack_d   = 2'b00;
        rd_ack_d   = 2'b00;
        err_d      = 2'b00;
        rdata_d    = rdata_q;
        overrun_d  = overrun_q;
        timeout_d  = 1'b0;
        grant      = 1'b0;
        owner_busy = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (slot_q[0].valid || slot_q[1].valid) begin
                    if (slot_q[0].valid && slot_q[1].valid) grant = ~last_q;
                    else                                    grant = slot_q[1].valid;
                    m_addr_d             = slot_q[grant].addr;
                    m_wdata_d            = slot_q[grant].wdata;
                    m_wr_req_d           = slot_q[grant].wr;
                    m_rd_req_d           = ~slot_q[grant].wr;
                    kind_d               = slot_q[grant].wr;
                    slot_d[grant].valid  = 1'b0;
                    last_d               = grant;
                    owner_d              = grant;
                    cnt_d                = '0;
                    state_d              = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if ((kind_q && m_wr_ack) || (!kind_q && m_rd_ack)) begin
                    if (kind_q) begin
                        wr_ack_d[owner_q] = 1'b1;
                    end else begin
                        rd_ack_d[owner_q] = 1'b1;
                        rdata_d[owner_q]  = m_rdata;
                    end
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                    // Abort: complete with err and all-ones read data.
                    if (kind_q) begin
                        wr_ack_d[owner_q] = 1'b1;
                    end else begin
                        rd_ack_d[owner_q] = 1'b1;
                        rdata_d[owner_q]  = '1;
                    end
                    err_d[owner_q] = 1'b1;
                    timeout_d      = 1'b1;
                    cnt_d          = '0;
                    state_d        = ST_IDLE;
                end else begin
                    cnt_d = CNT_W'(cnt_q + 1'b1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        for (int i = 0; i < 2; i++) begin
            owner_busy = (state_q == ST_WAIT) && (owner_q == 1'(i));
            if (req_wr[i] || req_rd[i]) begin
                if (slot_q[i].valid || owner_busy) begin
                    overrun_d = 1'b1;
                end else begin
                    slot_d[i].valid = 1'b1;
                    slot_d[i].wr    = req_wr[i];
                    slot_d[i].addr  = req_addr[i];
                    slot_d[i].wdata = req_wdata[i];
                    if (req_wr[i] && req_rd[i]) overrun_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q    <= ST_IDLE;
            for (int i = 0; i < 2; i++) begin
                slot_q[i]  <= '0;
                rdata_q[i] <= '0;
            end
            last_q     <= 1'b1;
            owner_q    <= 1'b0;
            kind_q     <= 1'b0;
            cnt_q      <= '0;
            m_wr_req_q <= 1'b0;
            m_rd_req_q <= 1'b0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            wr_ack_q   <= 2'b00;
            rd_ack_q   <= 2'b00;
            err_q      <= 2'b00;
            overrun_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            slot_q     <= slot_d;
            rdata_q    <= rdata_d;
            last_q     <= last_d;
            owner_q    <= owner_d;
            kind_q     <= kind_d;
            cnt_q      <= cnt_d;
            m_wr_req_q <= m_wr_req_d;
            m_rd_req_q <= m_rd_req_d;
            m_addr_q   <= m_addr_d;
            m_wdata_q  <= m_wdata_d;
            wr_ack_q   <= wr_ack_d;
            rd_ack_q   <= rd_ack_d;
            err_q      <= err_d;
            overrun_q  <= overrun_d;
            timeout_q  <= timeout_d;
        end
    end

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Directed self-checking bench for reg_bus_arbiter (TIMEOUT=4).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_reg_bus_arbiter;

    logic        aclk;
    logic        areset;
    logic        s0_wr_req, s0_rd_req, s1_wr_req, s1_rd_req;
    logic [7:0]  s0_addr, s1_addr;
    logic [31:0] s0_wdata, s1_wdata;
    logic        s0_wr_ack, s0_rd_ack, s0_err, s1_wr_ack, s1_rd_ack, s1_err;
    logic [31:0] s0_rdata, s1_rdata;
    logic        m_wr_req, m_rd_req, m_wr_ack, m_rd_ack;
    logic [7:0]  m_addr;
    logic [31:0] m_wdata, m_rdata;
    logic        overrun, timeout;

    int errors = 0;
    int checks = 0;

    reg_bus_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .TIMEOUT(4)) dut (
        .aclk(aclk), .areset(areset),
        .s0_wr_req(s0_wr_req), .s0_rd_req(s0_rd_req), .s0_addr(s0_addr), .s0_wdata(s0_wdata),
        .s0_wr_ack(s0_wr_ack), .s0_rd_ack(s0_rd_ack), .s0_rdata(s0_rdata), .s0_err(s0_err),
        .s1_wr_req(s1_wr_req), .s1_rd_req(s1_rd_req), .s1_addr(s1_addr), .s1_wdata(s1_wdata),
        .s1_wr_ack(s1_wr_ack), .s1_rd_ack(s1_rd_ack), .s1_rdata(s1_rdata), .s1_err(s1_err),
        .m_wr_req(m_wr_req), .m_rd_req(m_rd_req), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_wr_ack(m_wr_ack), .m_rd_ack(m_rd_ack), .m_rdata(m_rdata),
        .overrun(overrun), .timeout(timeout)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic reset_dut();
        areset = 1'b1;
        tick();
        areset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        areset = 1'b1;
        tick();
        checks++;
        if ({m_wr_req, m_rd_req, s0_wr_ack, s0_rd_ack, s0_err, s1_wr_ack, s1_rd_ack, s1_err,
             overrun, timeout} !== 10'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b want 0", {m_wr_req, m_rd_req, s0_wr_ack, s0_rd_ack,
                     s0_err, s1_wr_ack, s1_rd_ack, s1_err, overrun, timeout});
        end
        checks++;
        if (m_addr !== 8'h00 || m_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_bus: addr %h wdata %h want 0", m_addr, m_wdata);
        end
        checks++;
        if (s0_rdata !== 32'h0 || s1_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_rdata: %h %h want 0", s0_rdata, s1_rdata);
        end
        areset = 1'b0;
        tick();
        checks++;
        if (m_wr_req !== 1'b0 || m_rd_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: req %b%b want 00", m_wr_req, m_rd_req);
        end
    endtask

    task automatic test_single_write();
        s0_addr = 8'h04; s0_wdata = 32'h1234_5678; s0_wr_req = 1'b1;
        tick();
        s0_wr_req = 1'b0;
        checks++;
        if (m_wr_req !== 1'b0) begin
            errors++; $display("FAIL single_early: m_wr_req %b want 0", m_wr_req);
        end
        tick();
        checks++;
        if (m_wr_req !== 1'b1 || m_rd_req !== 1'b0 || m_addr !== 8'h04 || m_wdata !== 32'h1234_5678) begin
            errors++;
            $display("FAIL single_issue: wr %b rd %b addr %h data %h want 1 0 04 12345678",
                     m_wr_req, m_rd_req, m_addr, m_wdata);
        end
        m_wr_ack = 1'b1;
        tick();
        m_wr_ack = 1'b0;
        checks++;
        if (s0_wr_ack !== 1'b1 || s0_err !== 1'b0 || s1_wr_ack !== 1'b0 || m_wr_req !== 1'b0) begin
            errors++;
            $display("FAIL single_ack: ack %b err %b s1 %b mreq %b want 1 0 0 0",
                     s0_wr_ack, s0_err, s1_wr_ack, m_wr_req);
        end
        tick();
        checks++;
        if (s0_wr_ack !== 1'b0 || m_addr !== 8'h04) begin
            errors++; $display("FAIL single_after: ack %b addr %h want 0 04", s0_wr_ack, m_addr);
        end
    endtask

    task automatic test_simul_reads();
        reset_dut();
        s0_addr = 8'h00; s1_addr = 8'h08; s0_rd_req = 1'b1; s1_rd_req = 1'b1;
        tick();
        s0_rd_req = 1'b0; s1_rd_req = 1'b0;
        tick();
        checks++;
        if (m_rd_req !== 1'b1 || m_addr !== 8'h00) begin
            errors++; $display("FAIL simul_first: rd %b addr %h want 1 00", m_rd_req, m_addr);
        end
        m_rd_ack = 1'b1; m_rdata = 32'hA;
        tick();
        m_rd_ack = 1'b0; m_rdata = 32'h0;
        checks++;
        if (s0_rd_ack !== 1'b1 || s0_rdata !== 32'hA || s1_rd_ack !== 1'b0 || s0_err !== 1'b0) begin
            errors++;
            $display("FAIL simul_ack0: ack %b data %h s1 %b err %b want 1 a 0 0",
                     s0_rd_ack, s0_rdata, s1_rd_ack, s0_err);
        end
        tick();
        checks++;
        if (m_rd_req !== 1'b1 || m_addr !== 8'h08) begin
            errors++; $display("FAIL simul_second: rd %b addr %h want 1 08", m_rd_req, m_addr);
        end
        m_rd_ack = 1'b1; m_rdata = 32'hB;
        tick();
        m_rd_ack = 1'b0; m_rdata = 32'h0;
        checks++;
        if (s1_rd_ack !== 1'b1 || s1_rdata !== 32'hB || s0_rd_ack !== 1'b0 || s0_rdata !== 32'hA) begin
            errors++;
            $display("FAIL simul_ack1: ack %b data %h s0ack %b s0data %h want 1 b 0 a",
                     s1_rd_ack, s1_rdata, s0_rd_ack, s0_rdata);
        end
        tick();
    endtask

    task automatic test_alternate();
        int expg;
        int n0;
        int n1;
        bit found;
        s0_addr = 8'h10; s1_addr = 8'h20; s0_wdata = 32'h1; s1_wdata = 32'h2;
        s0_wr_req = 1'b1; s1_wr_req = 1'b1;
        tick();
        s0_wr_req = 1'b0; s1_wr_req = 1'b0;
        expg = 0; n0 = 0; n1 = 0;
        for (int r = 0; r < 8; r++) begin
            found = 1'b0;
            for (int k = 0; k < 6 && !found; k++) begin
                if (m_wr_req === 1'b1) found = 1'b1;
                else tick();
            end
            checks++;
            if (!found) begin
                errors++; $display("FAIL alt_grant_round%0d: m_wr_req %b want 1 within 6 cycles", r, m_wr_req);
            end
            checks++;
            if (m_addr !== ((expg == 0) ? 8'h10 : 8'h20)) begin
                errors++; $display("FAIL alt_owner_round%0d: addr %h want requester %0d", r, m_addr, expg);
            end
            m_wr_ack = 1'b1;
            tick();
            m_wr_ack = 1'b0;
            n0 += int'(s0_wr_ack);
            n1 += int'(s1_wr_ack);
            checks++;
            if ({s1_wr_ack, s0_wr_ack} !== ((expg == 0) ? 2'b01 : 2'b10) || m_wr_req !== 1'b0) begin
                errors++;
                $display("FAIL alt_ack_round%0d: acks %b mreq %b want %0d-hot, 0",
                         r, {s1_wr_ack, s0_wr_ack}, m_wr_req, expg);
            end
            if (r < 6) begin
                if (expg == 0) s0_wr_req = 1'b1;
                else           s1_wr_req = 1'b1;
            end
            tick();
            s0_wr_req = 1'b0; s1_wr_req = 1'b0;
            expg ^= 1;
        end
        checks++;
        if (n0 != 4 || n1 != 4 || overrun !== 1'b0) begin
            errors++; $display("FAIL alt_totals: acks %0d/%0d overrun %b want 4/4 0", n0, n1, overrun);
        end
    endtask

    task automatic test_timeout();
        s1_addr = 8'h30; s1_rd_req = 1'b1;
        tick();
        s1_rd_req = 1'b0;
        tick();
        checks++;
        if (m_rd_req !== 1'b1 || m_addr !== 8'h30) begin
            errors++; $display("FAIL to_issue: rd %b addr %h want 1 30", m_rd_req, m_addr);
        end
        for (int t = 1; t <= 5; t++) begin
            tick();
            m_wr_ack = (t == 1);
            if (t < 5) begin
                checks++;
                if (s1_rd_ack !== 1'b0 || timeout !== 1'b0) begin
                    errors++; $display("FAIL to_early_%0d: ack %b timeout %b want 0 0", t, s1_rd_ack, timeout);
                end
            end
        end
        m_wr_ack = 1'b0;
        checks++;
        if (s1_rd_ack !== 1'b1 || s1_err !== 1'b1 || s1_rdata !== 32'hFFFF_FFFF || timeout !== 1'b1) begin
            errors++;
            $display("FAIL to_abort: ack %b err %b data %h timeout %b want 1 1 ffffffff 1",
                     s1_rd_ack, s1_err, s1_rdata, timeout);
        end
        tick();
        checks++;
        if (timeout !== 1'b0 || s1_err !== 1'b0 || s1_rd_ack !== 1'b0) begin
            errors++; $display("FAIL to_pulse: timeout %b err %b ack %b want 0 0 0", timeout, s1_err, s1_rd_ack);
        end
        tick();
        m_rd_ack = 1'b1; m_rdata = 32'h55;
        tick();
        m_rd_ack = 1'b0; m_rdata = 32'h0;
        checks++;
        if (s1_rd_ack !== 1'b0 || s0_rd_ack !== 1'b0 || s1_rdata !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL to_late_ack: s1 %b s0 %b data %h want 0 0 ffffffff", s1_rd_ack, s0_rd_ack, s1_rdata);
        end
        // Ack on the final count cycle completes normally.
        s0_addr = 8'h3C; s0_wdata = 32'hCAFE; s0_wr_req = 1'b1;
        tick();
        s0_wr_req = 1'b0;
        tick();
        for (int t = 1; t <= 4; t++) tick();
        m_wr_ack = 1'b1;
        tick();
        m_wr_ack = 1'b0;
        checks++;
        if (s0_wr_ack !== 1'b1 || s0_err !== 1'b0 || timeout !== 1'b0) begin
            errors++; $display("FAIL to_edge_ack: ack %b err %b timeout %b want 1 0 0", s0_wr_ack, s0_err, timeout);
        end
        tick();
    endtask

    task automatic test_overrun();
        checks++;
        if (overrun !== 1'b0) begin
            errors++; $display("FAIL ovr_pre: overrun %b want 0", overrun);
        end
        s0_addr = 8'h40; s0_wdata = 32'hBEEF; s0_wr_req = 1'b1; s0_rd_req = 1'b1;
        tick();
        s0_wr_req = 1'b0; s0_rd_req = 1'b0;
        tick();
        checks++;
        if (m_wr_req !== 1'b1 || m_rd_req !== 1'b0 || overrun !== 1'b1) begin
            errors++; $display("FAIL ovr_issue: wr %b rd %b overrun %b want 1 0 1", m_wr_req, m_rd_req, overrun);
        end
        m_wr_ack = 1'b1;
        tick();
        m_wr_ack = 1'b0;
        for (int t = 0; t < 4; t++) begin
            tick();
            checks++;
            if (m_rd_req !== 1'b0 || overrun !== 1'b1) begin
                errors++; $display("FAIL ovr_hold_%0d: rd %b overrun %b want 0 1", t, m_rd_req, overrun);
            end
        end
        reset_dut();
        checks++;
        if (overrun !== 1'b0) begin
            errors++; $display("FAIL ovr_clear: overrun %b want 0", overrun);
        end
    endtask

    task automatic test_reset_mid_wait();
        s1_addr = 8'h50; s1_wdata = 32'h5050; s1_wr_req = 1'b1;
        tick();
        s1_wr_req = 1'b0;
        tick();
        checks++;
        if (m_wr_req !== 1'b1) begin
            errors++; $display("FAIL rmw_issue: m_wr_req %b want 1", m_wr_req);
        end
        areset = 1'b1;
        #1;
        checks++;
        if ({m_wr_req, m_rd_req, s1_wr_ack, s1_err, timeout, overrun} !== 6'b0 ||
            m_addr !== 8'h00 || m_wdata !== 32'h0) begin
            errors++;
            $display("FAIL rmw_clear: flags %b addr %h data %h want 0", {m_wr_req, m_rd_req, s1_wr_ack,
                     s1_err, timeout, overrun}, m_addr, m_wdata);
        end
        tick();
        areset = 1'b0;
        m_wr_ack = 1'b1;
        tick();
        m_wr_ack = 1'b0;
        for (int t = 0; t < 6; t++) begin
            tick();
            checks++;
            if (s1_wr_ack !== 1'b0 || m_wr_req !== 1'b0) begin
                errors++; $display("FAIL rmw_noack_%0d: ack %b mreq %b want 0 0", t, s1_wr_ack, m_wr_req);
            end
        end
        s0_addr = 8'h60; s0_rd_req = 1'b1;
        tick();
        s0_rd_req = 1'b0;
        tick();
        checks++;
        if (m_rd_req !== 1'b1 || m_addr !== 8'h60) begin
            errors++; $display("FAIL rmw_new_issue: rd %b addr %h want 1 60", m_rd_req, m_addr);
        end
        m_rd_ack = 1'b1; m_rdata = 32'h77;
        tick();
        m_rd_ack = 1'b0; m_rdata = 32'h0;
        checks++;
        if (s0_rd_ack !== 1'b1 || s0_rdata !== 32'h77 || s0_err !== 1'b0) begin
            errors++; $display("FAIL rmw_new_ack: ack %b data %h err %b want 1 77 0", s0_rd_ack, s0_rdata, s0_err);
        end
        tick();
    endtask

    initial begin
        areset = 1'b1;
        s0_wr_req = 1'b0; s0_rd_req = 1'b0; s0_addr = '0; s0_wdata = '0;
        s1_wr_req = 1'b0; s1_rd_req = 1'b0; s1_addr = '0; s1_wdata = '0;
        m_wr_ack = 1'b0; m_rd_ack = 1'b0; m_rdata = '0;
        test_reset();
        test_single_write();
        test_simul_reads();
        test_alternate();
        test_timeout();
        test_overrun();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
